bin2bcd_stream: RTL and testbench

- Parametrised iterative binary-to-BCD converter using shift-add-3 (double dabble).
- Generalises the fixed 37-bit / 11-digit converter to any binary width and digit count.
- Adds valid/ready handshakes on input and output, a sticky overflow flag and a significant-digit count.
- Sits between arithmetic/counter blocks and display or UART formatters.

---
 rtl/bin2bcd_pkg.sv | 27 ++
 rtl/bcd_digit_cell.sv | 34 +++
 rtl/bin2bcd_stream.sv | 149 ++++++++++++++
 tb/tb_bin2bcd_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM encoding and width helper for the bin2bcd_stream converter.
package bin2bcd_pkg;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] ADD3_THRESH = 4'd5;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble chain: add-3 correction then shift-left by one,
// with the corrected MSB passed up as carry to the next digit.
module bcd_digit_cell
    import bin2bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [DIG_W-1:0] digit,
    output logic [DIG_W-1:0] digit_nxt,
    output logic             carry_out
);

    logic [DIG_W-1:0] corr;

    always_comb begin
        corr      = (digit >= ADD3_THRESH) ? (digit + DIG_W'(3)) : digit;
        digit_nxt = {corr[DIG_W-2:0], ser_in};
        carry_out = corr[DIG_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (shift_en) begin
            digit <= digit_nxt;
        end
    end

endmodule

// File: rtl/bin2bcd_stream.sv
// Iterative binary-to-BCD converter with valid/ready on both sides, sticky overflow
// and significant-digit count. Define SIGNED_INPUT_EN to treat bin as two's complement.
//
//  state | meaning
//  IDLE  | waiting for an input; in_ready high
//  SHIFT | one double-dabble step per cycle, BIN_W cycles
//  DONE  | result held on outputs until out_ready; can accept next input same cycle
module bin2bcd_stream
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 37,
    parameter int DIGITS = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIN_W-1:0]               bin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DIG_W*DIGITS-1:0]        bcd,
    output logic [clog2(DIGITS+1)-1:0]     sig_digits,
    output logic                           overflow,
    output logic                           neg
);

    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int SIG_W = clog2(DIGITS + 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sr_q;
    logic [BIN_W-1:0]   load_val;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q, ovf_nxt;
    logic [SIG_W-1:0]   sig_q, sig_nxt;
    logic               load, shift_en, last, rdy_c;
    logic [DIGITS:0]    carry;
    logic [DIG_W-1:0]   dig     [DIGITS];
    logic [DIG_W-1:0]   dig_nxt [DIGITS];

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        rdy_c     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                rdy_c     = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held low for the whole reset, including the combinational IDLE decode.
    assign in_ready = rdy_c & rst_n;
    assign last     = shift_en && (cnt_q == CNT_W'(1));

    assign carry[0] = sr_q[BIN_W-1];
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (load),
            .shift_en  (shift_en),
            .ser_in    (carry[k]),
            .digit     (dig[k]),
            .digit_nxt (dig_nxt[k]),
            .carry_out (carry[k+1])
        );
        assign bcd[DIG_W*k +: DIG_W] = dig[k];
    end

    assign ovf_nxt = ovf_q | carry[DIGITS];

    // Counted from the post-shift digits so it is ready on the final SHIFT edge.
    always_comb begin
        sig_nxt = SIG_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_nxt[k] != '0) sig_nxt = SIG_W'(k + 1);
        end
        if (ovf_nxt) sig_nxt = SIG_W'(DIGITS);
    end

`ifdef SIGNED_INPUT_EN
    logic neg_q;

    // Magnitude as unsigned BIN_W bits, so the most negative value maps to 2^(BIN_W-1).
    assign load_val = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
    assign neg      = neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= bin[BIN_W-1];
        end
    end
`else
    assign load_val = bin;
    assign neg      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sr_q  <= load_val;
                cnt_q <= CNT_W'(BIN_W);
                ovf_q <= 1'b0;
            end else if (shift_en) begin
                sr_q  <= {sr_q[BIN_W-2:0], 1'b0};
                cnt_q <= cnt_q - CNT_W'(1);
                ovf_q <= ovf_nxt;
                if (last) sig_q <= sig_nxt;
            end
        end
    end

    assign sig_digits = sig_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Self-checking bench for bin2bcd_stream: directed cases plus random values against
// an arithmetic decimal model; also exercises backpressure, back-to-back and mid-run reset.
module tb_bin2bcd_stream;

`ifdef SIGNED_INPUT_EN
    localparam int BW = 8;
    localparam int DG = 3;
`else
    localparam int BW = 37;
    localparam int DG = 11;
`endif
    localparam int SW = $clog2(DG + 1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     bin;
    logic              out_valid;
    logic              out_ready;
    logic [4*DG-1:0]   bcd;
    logic [SW-1:0]     sig_digits;
    logic              overflow;
    logic              neg;

    int tests = 0;
    int fails = 0;

    bin2bcd_stream #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bcd        (bcd),
        .sig_digits (sig_digits),
        .overflow   (overflow),
        .neg        (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: plain integer arithmetic on the value, no shift-add-3.
    function automatic void model(input logic [BW-1:0] b, output logic [4*DG-1:0] eb,
                                  output logic [SW-1:0] es, output logic eo, output logic en);
        longint unsigned v, p, d;
        v  = 64'(b);
        en = 1'b0;
`ifdef SIGNED_INPUT_EN
        if (b[BW-1]) begin
            en = 1'b1;
            v  = (64'd1 << BW) - v;
        end
`endif
        p = 1;
        repeat (DG) p = p * 10;
        eo = (v >= p);
        v  = v % p;
        eb = '0;
        es = SW'(1);
        for (int k = 0; k < DG; k++) begin
            d = v % 10;
            eb[4*k +: 4] = d[3:0];
            if (d != 0) es = SW'(k + 1);
            v = v / 10;
        end
        if (eo) es = SW'(DG);
    endfunction

    function automatic logic [BW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) r = r % 64'd2000;
        return r[BW-1:0];
    endfunction

    task automatic send(input logic [BW-1:0] b);
        @(negedge clk);
        chk("send_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        bin      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin      = rnd();
    endtask

    // Starts just after the accepting edge; ends just after the output handshake edge.
    task automatic collect(input logic [BW-1:0] b, input string tag, input int hold,
                           input bit chain, input logic [BW-1:0] nb);
        logic [4*DG-1:0] eb;
        logic [SW-1:0]   es;
        logic            eo, en;
        int              cyc;
        model(b, eb, es, eo, en);
        cyc = 0;
        while (cyc < 4*BW + 10) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
            chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            in_valid = ($urandom_range(0, 1) == 1);
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(BW + 1));
        if (!out_valid) return;
        chk({tag, "_bcd"}, 64'(bcd), 64'(eb));
        chk({tag, "_sig"}, 64'(sig_digits), 64'(es));
        chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
        chk({tag, "_neg"}, 64'(neg), 64'(en));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_bcd"}, 64'(bcd), 64'(eb));
            chk({tag, "_hold_sig"}, 64'(sig_digits), 64'(es));
            chk({tag, "_hold_ovf"}, 64'(overflow), 64'(eo));
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid = 1'b1;
            bin      = nb;
        end
        #1;
        chk({tag, "_done_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [BW-1:0] cur, nxt;
        bit            ch;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_sig", 64'(sig_digits), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

`ifdef SIGNED_INPUT_EN
        send(8'h80); collect(8'h80, "min_neg", 0, 1'b0, '0);
        send(8'h7F); collect(8'h7F, "max_pos", 0, 1'b0, '0);
        send(8'hFF); collect(8'hFF, "minus1", 0, 1'b0, '0);
        send(8'h00); collect(8'h00, "zero", 0, 1'b0, '0);
        send(8'h9C); collect(8'h9C, "bp_m100", 5, 1'b1, 8'h64);
        collect(8'h64, "chain_100", 0, 1'b0, '0);
        cur = 8'h09;
`else
        send('0); collect('0, "zero", 0, 1'b0, '0);
        send(37'd99999999999); collect(37'd99999999999, "all9", 0, 1'b0, '0);
        send(37'd100000000000); collect(37'd100000000000, "ovf_edge", 0, 1'b0, '0);
        send(37'h1F_FFFF_FFFF); collect(37'h1F_FFFF_FFFF, "ovf_max", 0, 1'b0, '0);
        send(37'd1234); collect(37'd1234, "bp_1234", 5, 1'b1, 37'd56);
        collect(37'd56, "chain_56", 0, 1'b0, '0);
        cur = 37'd777;
`endif

        send(cur);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_bcd", 64'(bcd), 64'd0);
        chk("midrst_sig", 64'(sig_digits), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_neg", 64'(neg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(BW'(42)); collect(BW'(42), "after_rst_42", 0, 1'b0, '0);

        cur = rnd();
        send(cur);
        for (int i = 0; i < 20; i++) begin
            nxt = rnd();
            ch  = ($urandom_range(0, 1) == 1);
            collect(cur, "rand", $urandom_range(0, 2), ch, nxt);
            if (!ch) send(nxt);
            cur = nxt;
        end
        collect(cur, "rand_last", 0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
